// File: rtl/matmul_result_drain.sv
// matmul_result_drain
//
// Sits behind the 8x8 systolic matmul unit. Captures a burst of result rows
// (one per cycle while c_data_available is high) into a local row buffer,
// then drains the buffered rows one per handshake onto the vector
// register-file writeback port. Row i goes to register in_dst + i (wrapping),
// rows whose row-mask bit is clear are skipped at no cycle cost, and a new
// burst may begin on the same cycle as the final writeback of the previous one.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   c_data_available  a result row is present on c_data
//   c_data            result row, lane 0 in the least significant element
//   in_dst            base destination register (sampled with the first row)
//   in_lane_mask      lane write mask (sampled with the first row)
//   in_row_mask       per-row write enable (sampled with the first row)
//   wb_valid/wb_ready writeback handshake
//   wb_data           row being written
//   wb_dst            destination register id
//   wb_mask           lane mask for the write
//   busy              capturing or draining
//   done              one-cycle pulse after the last writeback of a burst
//   overflow_err      sticky: a row arrived that could not be accepted
module matmul_result_drain #(
   parameter int MAT_MUL_SIZE      = 8,
   parameter int LOG2_MAT_MUL_SIZE = 3,
   parameter int DWIDTH            = 32,
   parameter int REGIDWIDTH        = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           c_data_available,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data,
   input  logic [REGIDWIDTH-1:0]          in_dst,
   input  logic [MAT_MUL_SIZE-1:0]        in_lane_mask,
   input  logic [MAT_MUL_SIZE-1:0]        in_row_mask,
   output logic                           wb_valid,
   input  logic                           wb_ready,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] wb_data,
   output logic [REGIDWIDTH-1:0]          wb_dst,
   output logic [MAT_MUL_SIZE-1:0]        wb_mask,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow_err
);

   localparam int CW = LOG2_MAT_MUL_SIZE + 1;
   localparam int RW = MAT_MUL_SIZE * DWIDTH;
   localparam logic [CW-1:0] FULL = CW'(MAT_MUL_SIZE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DRAIN
   } state_t;

   state_t                        state, state_d;
   logic [CW-1:0]                 cnt, cnt_d, cnt_after;
   logic [CW-1:0]                 rp, rp_d, nxt;
   logic                          wb_valid_d, done_d, ovf_set;
   logic                          wr_en, latch, load, bypass;
   logic [LOG2_MAT_MUL_SIZE-1:0]  wr_idx, sel;

   logic [RW-1:0]                 row_buf [MAT_MUL_SIZE];
   logic [REGIDWIDTH-1:0]         base_q;
   logic [MAT_MUL_SIZE-1:0]       lane_mask_q;
   logic [MAT_MUL_SIZE-1:0]       row_mask_q;

   // Lowest index in [start, limit) whose mask bit is set; FULL when none.
   function automatic logic [CW-1:0] next_row(input logic [MAT_MUL_SIZE-1:0] mask,
                                              input logic [CW-1:0]           start,
                                              input logic [CW-1:0]           limit);
      logic [CW-1:0] res;
      res = FULL;
      for (int i = MAT_MUL_SIZE - 1; i >= 0; i--) begin
         if (mask[i] && (CW'(i) >= start) && (CW'(i) < limit)) res = CW'(i);
      end
      return res;
   endfunction

   assign busy = (state != S_IDLE);

   // Next-state and datapath control
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      cnt_after  = cnt;
      rp_d       = rp;
      nxt        = FULL;
      wb_valid_d = wb_valid;
      done_d     = 1'b0;
      ovf_set    = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = cnt[LOG2_MAT_MUL_SIZE-1:0];
      latch      = 1'b0;
      load       = 1'b0;
      sel        = rp[LOG2_MAT_MUL_SIZE-1:0];
      bypass     = 1'b0;

      case (state)
         S_IDLE: begin
            if (c_data_available) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               latch   = 1'b1;
               cnt_d   = CW'(1);
               state_d = S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            if (c_data_available) begin
               if (cnt < FULL) wr_en = 1'b1;
               else            ovf_set = 1'b1;
            end
            cnt_after = cnt + CW'(wr_en);
            cnt_d     = cnt_after;
            if (!c_data_available || (cnt_after == FULL)) begin
               nxt = next_row(row_mask_q, '0, cnt_after);
               if (nxt < FULL) begin
                  state_d    = S_DRAIN;
                  rp_d       = nxt;
                  load       = 1'b1;
                  sel        = nxt[LOG2_MAT_MUL_SIZE-1:0];
                  // The first row to drain may be the one arriving this cycle;
                  // it is not in the buffer yet, so take it straight from c_data.
                  bypass     = wr_en && (nxt == cnt);
                  wb_valid_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         S_DRAIN: begin
            if (wb_ready) begin
               nxt = next_row(row_mask_q, rp + CW'(1), cnt);
               if (nxt < FULL) begin
                  rp_d    = nxt;
                  load    = 1'b1;
                  sel     = nxt[LOG2_MAT_MUL_SIZE-1:0];
                  ovf_set = c_data_available;
               end else begin
                  wb_valid_d = 1'b0;
                  done_d     = 1'b1;
                  // Final handshake: a row arriving now opens the next burst.
                  if (c_data_available) begin
                     wr_en   = 1'b1;
                     wr_idx  = '0;
                     latch   = 1'b1;
                     cnt_d   = CW'(1);
                     state_d = S_CAPTURE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else begin
               ovf_set = c_data_available;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         rp           <= '0;
         wb_valid     <= 1'b0;
         done         <= 1'b0;
         overflow_err <= 1'b0;
         wb_data      <= '0;
         wb_dst       <= '0;
         wb_mask      <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         rp       <= rp_d;
         wb_valid <= wb_valid_d;
         done     <= done_d;
         if (ovf_set) overflow_err <= 1'b1;
         if (load) begin
            wb_data <= bypass ? c_data : row_buf[sel];
            wb_dst  <= base_q + REGIDWIDTH'(sel);
            wb_mask <= lane_mask_q;
         end
      end
   end

   // Row storage and per-burst attributes (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (wr_en) row_buf[wr_idx] <= c_data;
      if (latch) begin
         base_q      <= in_dst;
         lane_mask_q <= in_lane_mask;
         row_mask_q  <= in_row_mask;
      end
   end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Bench for matmul_result_drain: a queue-based reference model of bursts and
// pending writebacks, compared against the DUT on every cycle, plus directed
// scenarios whose observed writeback sequences are checked against literals.
module tb_matmul_result_drain;

   localparam int N   = 8;
   localparam int DW  = 32;
   localparam int RW  = N * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          cav;
   logic [RW-1:0] c_data;
   logic [7:0]    in_dst, in_lane_mask, in_row_mask;
   logic          wb_ready;
   logic          wb_valid;
   logic [RW-1:0] wb_data;
   logic [7:0]    wb_dst;
   logic [7:0]    wb_mask;
   logic          busy, done, overflow_err;

   always #5 clk = ~clk;

   matmul_result_drain #(
      .MAT_MUL_SIZE(8), .LOG2_MAT_MUL_SIZE(3), .DWIDTH(32), .REGIDWIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .c_data_available(cav), .c_data(c_data),
      .in_dst(in_dst), .in_lane_mask(in_lane_mask), .in_row_mask(in_row_mask),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_dst(wb_dst), .wb_mask(wb_mask), .busy(busy), .done(done),
      .overflow_err(overflow_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en   = 0;
   bit rand_rdy = 0;

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [RW-1:0] exp_data [$];
   logic [7:0]    exp_dst  [$];
   logic [7:0]    m_mask;
   logic [RW-1:0] cap_rows [$];
   bit            m_cap = 0, m_done = 0, m_ovf = 0;
   logic [7:0]    m_dst, m_lm, m_rm;

   task automatic start_cap();
      cap_rows.delete();
      cap_rows.push_back(c_data);
      m_dst = in_dst; m_lm = in_lane_mask; m_rm = in_row_mask;
      m_cap = 1;
   endtask

   always @(posedge clk) begin
      cyc++;
      m_done = 0;
      if (reset) begin
         exp_data.delete(); exp_dst.delete(); cap_rows.delete();
         m_cap = 0; m_ovf = 0;
      end else if (exp_data.size() > 0) begin
         if (wb_ready) begin
            void'(exp_data.pop_front());
            void'(exp_dst.pop_front());
            if (exp_data.size() == 0) begin
               m_done = 1;
               if (cav) start_cap();
            end else if (cav) m_ovf = 1;
         end else if (cav) m_ovf = 1;
      end else if (m_cap) begin
         if (cav) cap_rows.push_back(c_data);
         if (!cav || cap_rows.size() == N) begin
            m_cap = 0;
            for (int i = 0; i < cap_rows.size(); i++) begin
               if (m_rm[i]) begin
                  exp_data.push_back(cap_rows[i]);
                  exp_dst.push_back(8'(m_dst + i));
               end
            end
            m_mask = m_lm;
            if (exp_data.size() == 0) m_done = 1;
         end
      end else if (cav) start_cap();
   end

   // ---------------- compare + monitor ----------------
   int obs_dst [$];
   int obs_l0  [$];
   int obs_cyc [$];
   int done_cnt = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wb_valid", wb_valid, exp_data.size() > 0);
         chk("busy", busy, m_cap || (exp_data.size() > 0));
         chk("done", done, m_done);
         chk("overflow_err", overflow_err, m_ovf);
         if (exp_data.size() > 0) begin
            chk("wb_data", wb_data, exp_data[0]);
            chk("wb_dst", wb_dst, exp_dst[0]);
            chk("wb_mask", wb_mask, m_mask);
         end
      end
      if (wb_valid && wb_ready) begin
         obs_dst.push_back(int'(wb_dst));
         obs_l0.push_back(int'(wb_data[31:0]));
         obs_cyc.push_back(cyc + 1);
      end
      if (done) done_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) wb_ready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [RW-1:0] mkrow(input int idx, input int tag, input bit rnd);
      logic [RW-1:0] r;
      for (int k = 0; k < N; k++) begin
         if (rnd) r[k*DW +: DW] = $urandom;
         else     r[k*DW +: DW] = {8'(tag), 8'(k), 16'(idx)};
      end
      if (!rnd) r[DW-1:0] = 32'(idx);
      return r;
   endfunction

   task automatic send_burst(input int n, input logic [7:0] dst, input logic [7:0] lm,
                             input logic [7:0] rm, input int tag, input bit rnd);
      for (int i = 0; i < n; i++) begin
         cav    = 1'b1;
         c_data = mkrow(i, tag, rnd);
         // attributes only matter on the first row; scramble them afterwards
         in_dst       = (i == 0) ? dst : ~dst;
         in_lane_mask = (i == 0) ? lm  : ~lm;
         in_row_mask  = (i == 0) ? rm  : ~rm;
         step();
      end
      cav = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         step();
         k++;
      end
      chk("idle_timeout", busy, 1'b0);
      step();
      step();
   endtask

   task automatic clear_obs();
      obs_dst.delete(); obs_l0.delete(); obs_cyc.delete();
      done_cnt = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int skip_idx [4];
      int stall;
      int k;
      reset = 1'b1; cav = 1'b0; c_data = '0;
      in_dst = '0; in_lane_mask = '0; in_row_mask = '0; wb_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_overflow", overflow_err, 1'b0);
      chk("rst_wb_data", wb_data, '0);
      chk("rst_wb_dst", wb_dst, 8'h00);
      chk("rst_wb_mask", wb_mask, 8'h00);
      @(posedge clk); #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // full burst
      clear_obs();
      send_burst(8, 8'h10, 8'hFF, 8'hFF, 1, 0);
      wait_idle(40);
      chk("full_count", obs_dst.size(), 8);
      chk("full_done", done_cnt, 1);
      if (obs_dst.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("full_dst", obs_dst[i], 8'h10 + i);
            chk("full_lane0", obs_l0[i], i);
            chk("full_consecutive", obs_cyc[i] - obs_cyc[0], i);
         end
      end

      // row skipping 0xA5
      clear_obs();
      skip_idx = '{0, 2, 5, 7};
      send_burst(8, 8'h10, 8'hF0, 8'hA5, 2, 0);
      wait_idle(40);
      chk("skip_count", obs_dst.size(), 4);
      if (obs_dst.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("skip_dst", obs_dst[i], 8'h10 + skip_idx[i]);
            chk("skip_lane0", obs_l0[i], skip_idx[i]);
            chk("skip_consecutive", obs_cyc[i] - obs_cyc[0], i);
         end
      end

      // row mask 0: no writeback, done still pulses
      clear_obs();
      send_burst(3, 8'h30, 8'hFF, 8'h00, 3, 0);
      wait_idle(20);
      chk("nomask_count", obs_dst.size(), 0);
      chk("nomask_done", done_cnt, 1);

      // backpressure on row 2
      clear_obs();
      stall = 0;
      send_burst(8, 8'h20, 8'h3C, 8'hFF, 4, 0);
      k = 0;
      while ((busy || k == 0) && k < 60) begin
         if (wb_valid && wb_dst == 8'h22 && stall < 3) begin
            wb_ready = 1'b0;
            stall++;
         end else wb_ready = 1'b1;
         step();
         k++;
      end
      wb_ready = 1'b1;
      wait_idle(20);
      chk("bp_count", obs_dst.size(), 8);
      if (obs_dst.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("bp_dst", obs_dst[i], 8'h20 + i);
         chk("bp_stall_gap", obs_cyc[2] - obs_cyc[1], 4);
         chk("bp_lane0_row2", obs_l0[2], 2);
      end

      // short burst with register-id wrap
      clear_obs();
      send_burst(3, 8'hFE, 8'hFF, 8'hFF, 5, 0);
      wait_idle(20);
      chk("wrap_count", obs_dst.size(), 3);
      if (obs_dst.size() == 3) begin
         chk("wrap_dst0", obs_dst[0], 8'hFE);
         chk("wrap_dst1", obs_dst[1], 8'hFF);
         chk("wrap_dst2", obs_dst[2], 8'h00);
      end

      // back-to-back: next burst starts on the last handshake
      clear_obs();
      send_burst(3, 8'h40, 8'hFF, 8'hFF, 6, 0);
      k = 0;
      while (!(wb_valid && wb_dst == 8'h42) && k < 30) begin
         step();
         k++;
      end
      chk("b2b_wait_timeout", wb_valid && wb_dst == 8'h42, 1'b1);
      send_burst(2, 8'h50, 8'hFF, 8'hFF, 7, 0);
      wait_idle(30);
      chk("b2b_count", obs_dst.size(), 5);
      if (obs_dst.size() == 5) begin
         chk("b2b_dst2", obs_dst[2], 8'h42);
         chk("b2b_dst3", obs_dst[3], 8'h50);
         chk("b2b_dst4", obs_dst[4], 8'h51);
         chk("b2b_lane0_4", obs_l0[4], 1);
         chk("b2b_gap", obs_cyc[3] - obs_cyc[2], 3);
      end
      chk("b2b_done", done_cnt, 2);
      chk("b2b_no_overflow", overflow_err, 1'b0);

      // 9th consecutive row -> overflow, drain unaffected
      clear_obs();
      send_burst(9, 8'h60, 8'hFF, 8'hFF, 8, 0);
      wait_idle(40);
      chk("ovf_flag", overflow_err, 1'b1);
      chk("ovf_count", obs_dst.size(), 8);
      if (obs_dst.size() == 8) chk("ovf_last_dst", obs_dst[7], 8'h67);
      repeat (5) step();
      chk("ovf_sticky", overflow_err, 1'b1);

      // reset mid-drain after two writes
      clear_obs();
      send_burst(8, 8'h70, 8'hFF, 8'hFF, 9, 0);
      k = 0;
      while (obs_dst.size() < 2 && k < 30) begin
         step();
         k++;
      end
      reset    = 1'b1;
      wb_ready = 1'b0;
      step();
      reset    = 1'b0;
      wb_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", wb_valid, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_overflow", overflow_err, 1'b0);
      chk("rst_mid_writes", obs_dst.size(), 2);
      @(posedge clk); #1;
      repeat (3) step();
      chk("rst_mid_no_more", obs_dst.size(), 2);
      clear_obs();
      send_burst(2, 8'h80, 8'h0F, 8'hFF, 10, 0);
      wait_idle(20);
      chk("post_rst_count", obs_dst.size(), 2);
      if (obs_dst.size() == 2) begin
         chk("post_rst_dst0", obs_dst[0], 8'h80);
         chk("post_rst_lane0", obs_l0[0], 0);
         chk("post_rst_dst1", obs_dst[1], 8'h81);
      end

      // randomized bursts, gaps and backpressure
      rand_rdy = 1'b1;
      for (int b = 0; b < 80; b++) begin
         int n, sel;
         logic [7:0] rm;
         n   = $urandom_range(1, 9);
         sel = $urandom_range(0, 9);
         case (sel)
            0:       rm = 8'h00;
            1:       rm = 8'h80;
            2:       rm = 8'h01;
            default: rm = 8'($urandom);
         endcase
         send_burst(n, 8'($urandom), 8'($urandom), rm, b, 1);
         repeat ($urandom_range(0, 10)) step();
      end
      rand_rdy = 1'b0;
      wb_ready = 1'b1;
      wait_idle(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
